// File: rtl/rv_core_pkg.sv
// Shared RV32 field geometry and the decoded-field bundle used by the
// instruction queue and any later single-cycle decode paths.
package rv_core_pkg;

  localparam int ILEN     = 32;
  localparam int OPCODE_W = 7;
  localparam int FUNCT3_W = 3;
  localparam int FUNCT7_W = 7;
  localparam int REG_W    = 5;
  localparam int OP_W     = FUNCT7_W + FUNCT3_W + OPCODE_W;

  localparam int OPCODE_LSB = 0;
  localparam int RD_LSB     = 7;
  localparam int FUNCT3_LSB = 12;
  localparam int RS1_LSB    = 15;
  localparam int RS2_LSB    = 20;
  localparam int FUNCT7_LSB = 25;

  // Every 32-bit RV encoding has instr[1:0] == 2'b11; anything else is compressed or garbage.
  localparam logic [1:0] QUADRANT_32 = 2'b11;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic             illegal;
  } decoded_t;

endpackage

// File: rtl/rv_field_decode.sv
// Combinational split of a 32-bit RV word into {funct7,funct3,opcode},
// register indices and a coarse illegal-encoding flag.
module rv_field_decode
  import rv_core_pkg::*;
(
  input  logic [ILEN-1:0]  instr,
  output logic [OP_W-1:0]  op,
  output logic [REG_W-1:0] rs1,
  output logic [REG_W-1:0] rs2,
  output logic [REG_W-1:0] rd,
  output logic             illegal
);

  logic [OPCODE_W-1:0] opcode;
  logic [FUNCT3_W-1:0] funct3;
  logic [FUNCT7_W-1:0] funct7;

  always_comb begin
    opcode = instr[OPCODE_LSB +: OPCODE_W];
    funct3 = instr[FUNCT3_LSB +: FUNCT3_W];
    funct7 = instr[FUNCT7_LSB +: FUNCT7_W];
    op     = {funct7, funct3, opcode};
    rs1    = instr[RS1_LSB +: REG_W];
    rs2    = instr[RS2_LSB +: REG_W];
    rd     = instr[RD_LSB +: REG_W];
    // The all-zero word is defined as illegal so a freshly reset queue reads as such.
    illegal = (instr == '0) || (instr[1:0] != QUADRANT_32);
  end

endmodule

// File: rtl/instr_decode_queue.sv
// Fetch-to-decode instruction FIFO (DEPTH entries, power of two >= 2) that
// presents its head entry already split into RV32 fields.
module instr_decode_queue
  import rv_core_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ILEN-1:0]            in_instr,
  input  logic [XLEN-1:0]            in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OP_W-1:0]            out_op,
  output logic [REG_W-1:0]           out_rs1,
  output logic [REG_W-1:0]           out_rs2,
  output logic [REG_W-1:0]           out_rd,
  output logic [ILEN-1:0]            out_instr,
  output logic [XLEN-1:0]            out_pc,
  output logic                       out_illegal,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic push, pop, wr_en;

  logic [ILEN-1:0] word_arr [DEPTH];
  logic [XLEN-1:0] pc_arr   [DEPTH];

  logic [ILEN-1:0] head_word;
  decoded_t        head_dec;

  // Handshake status depends only on registered occupancy.
  assign in_ready  = (count_q < CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign wr_en     = push && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is cleared only by reset; flush just rewinds the pointers.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [ILEN-1:0] word_q, word_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            sel;

    assign sel = wr_en && (wr_ptr_q == PTR_W'(gi));

    always_comb begin
      word_d = word_q;
      pc_d   = pc_q;
      if (sel) begin
        word_d = in_instr;
        pc_d   = in_pc;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        word_q <= '0;
        pc_q   <= '0;
      end else begin
        word_q <= word_d;
        pc_q   <= pc_d;
      end
    end

    assign word_arr[gi] = word_q;
    assign pc_arr[gi]   = pc_q;
  end

  assign head_word = word_arr[rd_ptr_q];

  rv_field_decode u_head_decode (
    .instr   (head_word),
    .op      (head_dec.op),
    .rs1     (head_dec.rs1),
    .rs2     (head_dec.rs2),
    .rd      (head_dec.rd),
    .illegal (head_dec.illegal)
  );

  assign out_op      = head_dec.op;
  assign out_rs1     = head_dec.rs1;
  assign out_rs2     = head_dec.rs2;
  assign out_rd      = head_dec.rd;
  assign out_illegal = head_dec.illegal;
  assign out_instr   = head_word;
  assign out_pc      = pc_arr[rd_ptr_q];
  assign count       = count_q;

endmodule

// File: tb/tb_instr_decode_queue.sv
// Randomised and directed checks of instr_decode_queue against a queue-based model.
module tb_instr_decode_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } ent_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush, in_valid, out_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            in_ready, out_valid, out_illegal;
  logic [16:0]     out_op;
  logic [4:0]      out_rs1, out_rs2, out_rd;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_pc;
  logic [CW-1:0]   count;

  int total = 0;
  int bad   = 0;
  ent_t mq[$];

  always #5 clk = ~clk;

  instr_decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_instr(out_instr), .out_pc(out_pc), .out_illegal(out_illegal), .count(count)
  );

  // Field values from shifts and masks on the integer word.
  function automatic logic [16:0] m_op(input logic [31:0] w);
    int unsigned u;
    u = w;
    return 17'(((u >> 25) & 32'h7f) * 1024 + ((u >> 12) & 32'h7) * 128 + (u & 32'h7f));
  endfunction
  function automatic logic [4:0] m_reg(input logic [31:0] w, input int lsb);
    int unsigned u;
    u = w;
    return 5'((u >> lsb) % 32);
  endfunction
  function automatic logic m_illegal(input logic [31:0] w);
    int unsigned u;
    u = w;
    return (u == 0) || (u % 4 != 3);
  endfunction

  // Drive one cycle of inputs and advance the model across the edge.
  task automatic drive_cycle(input logic v, input logic [31:0] w, input logic [XLEN-1:0] p,
                             input logic rdy, input logic fl);
    bit do_push, do_pop;
    in_valid = v; in_instr = w; in_pc = p; out_ready = rdy; flush = fl;
    do_push = v && (mq.size() < DEPTH);
    do_pop  = rdy && (mq.size() > 0);
    @(posedge clk);
    if (fl) mq.delete();
    else begin
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back('{instr: w, pc: p});
    end
    #1;
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 0; in_valid = 0; out_ready = 0; in_instr = '0; in_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (count !== 0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_instr !== 32'h0 || out_pc !== '0 || out_op !== 17'h0)
      begin bad++; $display("FAIL reset_fields instr=%h pc=%h op=%h exp all 0", out_instr, out_pc, out_op); end
    total++; if (out_rs1 !== 0 || out_rs2 !== 0 || out_rd !== 0)
      begin bad++; $display("FAIL reset_regs rs1=%0d rs2=%0d rd=%0d exp 0", out_rs1, out_rs2, out_rd); end
    total++; if (out_illegal !== 1'b1) begin bad++; $display("FAIL reset_illegal got=%b exp=1", out_illegal); end
    rst = 1'b0;
    mq.delete();
  endtask

  task automatic test_addi();
    drive_cycle(1, 32'h00500093, 32'h0, 0, 0);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL addi_valid got=%b exp=1", out_valid); end
    total++; if (out_op !== 17'h00013) begin bad++; $display("FAIL addi_op got=%h exp=00013", out_op); end
    total++; if (out_rd !== 5'd1 || out_rs1 !== 5'd0 || out_rs2 !== 5'd5)
      begin bad++; $display("FAIL addi_regs rd=%0d rs1=%0d rs2=%0d exp 1 0 5", out_rd, out_rs1, out_rs2); end
    total++; if (out_illegal !== 1'b0) begin bad++; $display("FAIL addi_illegal got=%b exp=0", out_illegal); end
    total++; if (count !== 1) begin bad++; $display("FAIL addi_count got=%0d exp=1", count); end
    drive_cycle(0, '0, '0, 1, 0);
    total++; if (count !== 0) begin bad++; $display("FAIL addi_pop_count got=%0d exp=0", count); end
  endtask

  task automatic test_back_to_back();
    drive_cycle(1, 32'h002081B3, 32'h4, 1, 0);
    total++; if (out_op !== 17'h00033 || out_pc !== 32'h4)
      begin bad++; $display("FAIL b2b_first op=%h pc=%h exp 00033 4", out_op, out_pc); end
    drive_cycle(1, 32'h402081B3, 32'h8, 1, 0);
    total++; if (out_op !== 17'h08033 || out_pc !== 32'h8)
      begin bad++; $display("FAIL b2b_second op=%h pc=%h exp 08033 8", out_op, out_pc); end
    total++; if (out_rd !== 5'd3 || out_rs1 !== 5'd1 || out_rs2 !== 5'd2)
      begin bad++; $display("FAIL b2b_regs rd=%0d rs1=%0d rs2=%0d exp 3 1 2", out_rd, out_rs1, out_rs2); end
    total++; if (count !== 1) begin bad++; $display("FAIL b2b_count got=%0d exp=1", count); end
    drive_cycle(0, '0, '0, 1, 0);
    total++; if (count !== 0) begin bad++; $display("FAIL b2b_drain got=%0d exp=0", count); end
  endtask

  task automatic test_full();
    logic [31:0] w;
    for (int i = 0; i < DEPTH + 2; i++) begin
      total++; if (in_ready !== (i < DEPTH))
        begin bad++; $display("FAIL full_in_ready[%0d] got=%b exp=%b", i, in_ready, i < DEPTH); end
      w = 32'h00100013 + 32'(i) * 32'h00100000;
      drive_cycle(1, w, 32'h1000 + 32'(i * 4), 0, 0);
    end
    total++; if (count !== DEPTH) begin bad++; $display("FAIL full_count got=%0d exp=%0d", count, DEPTH); end
    for (int i = 0; i < DEPTH; i++) begin
      w = 32'h00100013 + 32'(i) * 32'h00100000;
      total++; if (out_instr !== w || out_pc !== 32'h1000 + 32'(i * 4))
        begin bad++; $display("FAIL full_drain[%0d] instr=%h pc=%h exp %h %h", i, out_instr, out_pc, w, 32'h1000 + 32'(i * 4)); end
      drive_cycle(0, '0, '0, 1, 0);
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL full_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < DEPTH; i++) drive_cycle(1, 32'h00000093 + 32'(i << 15), 32'h2000 + 32'(i * 4), 0, 0);
    drive_cycle(1, 32'hDEADBEEF, 32'h2FFC, 1, 0);
    total++; if (count !== DEPTH - 1) begin bad++; $display("FAIL fullpop_count got=%0d exp=%0d", count, DEPTH - 1); end
    total++; if (out_pc !== 32'h2004) begin bad++; $display("FAIL fullpop_head pc=%h exp=2004", out_pc); end
    drive_cycle(1, 32'h00A00113, 32'h3000, 0, 0);
    total++; if (count !== DEPTH || in_ready !== 1'b0)
      begin bad++; $display("FAIL fullpop_push count=%0d in_ready=%b exp %0d 0", count, in_ready, DEPTH); end
    while (mq.size() > 0) begin
      total++; if (out_instr !== mq[0].instr || out_pc !== mq[0].pc)
        begin bad++; $display("FAIL fullpop_drain instr=%h pc=%h exp %h %h", out_instr, out_pc, mq[0].instr, mq[0].pc); end
      drive_cycle(0, '0, '0, 1, 0);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) drive_cycle(1, 32'h00108093, 32'h4000 + 32'(i * 4), 0, 0);
    total++; if (count !== 3) begin bad++; $display("FAIL flush_pre got=%0d exp=3", count); end
    drive_cycle(1, 32'h00208093, 32'h400C, 1, 1);
    total++; if (count !== 0 || out_valid !== 1'b0 || in_ready !== 1'b1)
      begin bad++; $display("FAIL flush_after count=%0d out_valid=%b in_ready=%b exp 0 0 1", count, out_valid, in_ready); end
    drive_cycle(1, 32'h00000013, 32'h8000, 0, 0);
    total++; if (count !== 1 || out_instr !== 32'h00000013 || out_pc !== 32'h8000)
      begin bad++; $display("FAIL flush_push count=%0d instr=%h pc=%h exp 1 00000013 8000", count, out_instr, out_pc); end
    drive_cycle(0, '0, '0, 1, 0);
  endtask

  task automatic test_illegal();
    drive_cycle(1, 32'h0, 32'h100, 0, 0);
    drive_cycle(1, 32'h00000010, 32'h104, 0, 0);
    for (int i = 0; i < 2; i++) begin
      total++; if (out_illegal !== 1'b1 || out_valid !== 1'b1)
        begin bad++; $display("FAIL illegal[%0d] illegal=%b valid=%b exp 1 1", i, out_illegal, out_valid); end
      drive_cycle(0, '0, '0, 1, 0);
    end
    total++; if (count !== 0) begin bad++; $display("FAIL illegal_popped got=%0d exp=0", count); end
    drive_cycle(1, 32'h00500093, 32'h200, 0, 0);
    drive_cycle(1, 32'h00600093, 32'h204, 0, 0);
    rst = 1'b1;
    #1;
    total++; if (count !== 0 || in_ready !== 1'b1 || out_valid !== 1'b0)
      begin bad++; $display("FAIL async_reset count=%0d in_ready=%b out_valid=%b exp 0 1 0", count, in_ready, out_valid); end
    mq.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0]     w;
    logic [XLEN-1:0] p;
    for (int c = 0; c < 400; c++) begin
      total++; if (count !== CW'(mq.size()) || out_valid !== (mq.size() != 0) || in_ready !== (mq.size() < DEPTH))
        begin bad++; $display("FAIL rand_status[%0d] count=%0d valid=%b ready=%b exp %0d", c, count, out_valid, in_ready, mq.size()); end
      if (mq.size() > 0) begin
        total++; if (out_instr !== mq[0].instr || out_pc !== mq[0].pc || out_op !== m_op(mq[0].instr) ||
                     out_rs1 !== m_reg(mq[0].instr, 15) || out_rs2 !== m_reg(mq[0].instr, 20) ||
                     out_rd !== m_reg(mq[0].instr, 7) || out_illegal !== m_illegal(mq[0].instr))
          begin bad++; $display("FAIL rand_head[%0d] instr=%h pc=%h op=%h ill=%b exp %h %h %h %b", c,
                                out_instr, out_pc, out_op, out_illegal, mq[0].instr, mq[0].pc,
                                m_op(mq[0].instr), m_illegal(mq[0].instr)); end
      end
      w = $urandom;
      if ($urandom_range(0, 7) != 0) w[1:0] = 2'b11;
      p = XLEN'($urandom);
      drive_cycle(1'($urandom_range(0, 3) != 0), w, p, 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 31) == 0));
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_full();
    test_full_pop();
    test_flush();
    test_illegal();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
